// File: rtl/c2_shift_add_mult.sv
// Sequential unsigned SIZE x SIZE shift-add multiplier built around one ripple-carry C2Adder.
// One partial product per clock, with a start/ready/done handshake.

module c2_adder #(
  parameter int unsigned SIZE = 5
) (
  input  logic [SIZE-1:0] i1,
  input  logic [SIZE-1:0] i2,
  output logic [SIZE:0]   o
);

  logic [SIZE:0] cy;

  assign cy[0] = 1'b0;

  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    assign o[i]    = i1[i] ^ i2[i] ^ cy[i];
    assign cy[i+1] = (i1[i] & i2[i]) | (cy[i] & (i1[i] ^ i2[i]));
  end

  assign o[SIZE] = cy[SIZE];

endmodule

module c2_shift_add_mult #(
  parameter int unsigned SIZE = 5,
  parameter int unsigned CW   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              ready,
  output logic              done,
  output logic [2*SIZE-1:0] product
);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e              state_q, state_d;
  logic [SIZE-1:0]     m_q, m_d;
  logic [SIZE-1:0]     p_q, p_d;
  logic [SIZE-1:0]     q_q, q_d;
  logic [CW-1:0]       count_q, count_d;
  logic [2*SIZE-1:0]   product_q, product_d;

  logic [SIZE:0]       add_o;
  logic [SIZE:0]       gated;

  c2_adder #(
    .SIZE (SIZE)
  ) u_adder (
    .i1 (p_q),
    .i2 (m_q),
    .o  (add_o)
  );

  // Skip the add when the current multiplier bit is zero; carry can never be lost.
  assign gated = q_q[0] ? add_o : {1'b0, p_q};

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_d       = p_q;
    q_d       = q_q;
    count_d   = count_q;
    product_d = product_q;
    ready     = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (start) begin
          m_d     = a;
          q_d     = b;
          p_d     = '0;
          count_d = CW'(SIZE - 1);
          state_d = StAdd;
        end
      end
      StAdd: begin
        {p_d, q_d} = {gated, q_q[SIZE-1:1]};
        if (count_q == '0) begin
          product_d = {p_d, q_d};
          state_d   = StDone;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      m_q       <= '0;
      p_q       <= '0;
      q_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_q       <= p_d;
      q_q       <= q_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_c2_shift_add_mult.sv
// Directed self-checking bench for c2_shift_add_mult (SIZE=5): latency, handshake, abort,
// back-to-back operation and an exhaustive product sweep.

module tb_c2_shift_add_mult;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] a;
  logic [4:0] b;
  logic       ready;
  logic       done;
  logic [9:0] product;

  int checks   = 0;
  int failures = 0;
  logic [9:0] last_product = '0;

  c2_shift_add_mult #(
    .SIZE (5),
    .CW   (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one operation; done should appear 5 edges after the accepting edge.
  task automatic run_op(input logic [4:0] ia, input logic [4:0] ib, input logic [9:0] exp_p,
                        input bit full);
    int n;
    int ready_low;
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    if (full) check_eq("ready_before", 32'(ready), 32'd1);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    ready_low = 0;
    while (!done && n < 20) begin
      if (!ready) ready_low++;
      check_eq("hold", 32'(product), 32'(last_product));
      @(negedge clk);
      n++;
    end
    if (!ready) ready_low++;
    if (full) begin
      check_eq("latency", n, 5);
      check_eq("ready_low", ready_low, 6);
    end
    check_eq("product", 32'(product), 32'(exp_p));
    last_product = exp_p;
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;
    int last_cyc;
    logic [9:0] exp5 [3];
    exp5[0] = 10'd12;
    exp5[1] = 10'd63;
    exp5[2] = 10'd31;

    rst = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1, 2: basic products and zero operands
    run_op(5'd13, 5'd11, 10'd143, 1'b1);
    run_op(5'd31, 5'd31, 10'd961, 1'b1);
    run_op(5'd0, 5'd31, 10'd0, 1'b1);
    run_op(5'd31, 5'd0, 10'd0, 1'b1);

    // 3: a second start while busy is ignored
    @(negedge clk);
    a = 5'd5; b = 5'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 5'd1; b = 5'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) begin
        ndone++;
        check_eq("busy_product", 32'(product), 32'd30);
      end
      @(negedge clk);
    end
    check_eq("busy_done_count", ndone, 1);
    check_eq("busy_ready", 32'(ready), 32'd1);
    last_product = 10'd30;

    // 4: asynchronous abort during the third ADD cycle
    @(negedge clk);
    a = 5'd9; b = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_ready", 32'(ready), 32'd1);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_product", 32'(product), 32'd0);
    last_product = '0;
    @(negedge clk);
    rst = 1'b1;
    run_op(5'd9, 5'd7, 10'd63, 1'b1);

    // 5: start held high, operands change right after each acceptance
    @(negedge clk);
    a = 5'd3; b = 5'd4; start = 1'b1;
    ndone = 0;
    last_cyc = -1;
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      if (k == 0) begin a = 5'd7; b = 5'd9; end
      if (k == 7) begin a = 5'd31; b = 5'd1; end
      if (k == 14) start = 1'b0;
      if (done) begin
        if (ndone < 3) check_eq("b2b_product", 32'(product), 32'(exp5[ndone]));
        if (last_cyc >= 0) check_eq("b2b_spacing", k - last_cyc, 7);
        last_cyc = k;
        ndone++;
      end
    end
    check_eq("b2b_done_count", ndone, 3);
    last_product = 10'd31;

    // 6: exhaustive sweep
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        run_op(5'(i), 5'(j), 10'(i * j), 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
